// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard writer.
package kb_pkg;

    // Frame receiver states: start bit is consumed in IDLE, so DATA begins at bit 0.
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } kb_state_e;

    // Scan-code prefixes that modify the following byte instead of being written.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_kb_writer_if.sv
// Keyboard-port write bus into the data memory, plus the frame error pulse.
interface ps2_kb_writer_if;
    logic        we_kb;
    logic [31:0] addr_kb;
    logic [31:0] data_kb;
    logic        frame_err;

    modport master (output we_kb, output addr_kb, output data_kb, output frame_err);
    modport slave  (input  we_kb, input  addr_kb, input  data_kb, input  frame_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for ps2_clk/ps2_data and a falling-edge detector on the
// synchronized clock. The synchronized data is aligned with the edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic ps2_fall,
    output logic ps2_data_s
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic clk_meta_d, clk_sync_d, clk_prev_d;
    logic data_meta_d, data_sync_d;

    // Next-state of the synchronizer pipeline is a plain shift.
    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
    end

    // Synchronizer registers; reset to the bus idle level so no edge fires on release.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign ps2_fall   = clk_prev_q & ~clk_sync_q;
    assign ps2_data_s = data_sync_q;

endmodule

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard receiver that writes decoded scan codes to a fixed memory word.
// Optional feature: define KB_BREAK_CLEAR_EN to write 0 when a key is released;
// otherwise break codes leave the last make code in memory.
module ps2_kb_writer
    import kb_pkg::*;
#(
    parameter int KEY_ADDR    = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    ps2_kb_writer_if.master  kb
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic ps2_fall, ps2_bit;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_fall   (ps2_fall),
        .ps2_data_s (ps2_bit)
    );

    kb_state_e   state_q,   state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q,   shift_d;
    logic        par_err_q, par_err_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic        ext_q,     ext_d;
    logic        brk_q,     brk_d;
    logic        we_q,      we_d;
    logic        err_q,     err_d;
    logic [31:0] data_q,    data_d;

    // Frame FSM, prefix tracking and output strobes.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        tmo_d     = tmo_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;

        // Inter-edge watchdog: only runs while a frame is in progress.
        if (state_q != IDLE) begin
            if (ps2_fall) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (ps2_fall && !ps2_bit) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    par_err_d = 1'b0;
                end
            end
            DATA: begin
                if (ps2_fall) begin
                    shift_d   = {ps2_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (ps2_fall) begin
                    par_err_d = ~parity_ok(shift_q, ps2_bit);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (ps2_fall) begin
                    state_d = IDLE;
                    if (ps2_bit && !par_err_q) begin
                        if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (!brk_q) begin
                                we_d   = 1'b1;
                                data_d = {23'b0, ext_q, shift_q};
                            end else begin
`ifdef KB_BREAK_CLEAR_EN
                                we_d   = 1'b1;
                                data_d = 32'h0;
`endif
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned; prefixes are kept like any rejected frame.
        if (state_q != IDLE && !ps2_fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        // NOTE: the shift register and data word are reset too, so outputs are defined from reset.
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_err_q <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            we_q      <= we_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    assign kb.we_kb     = we_q;
    assign kb.frame_err = err_q;
    assign kb.data_kb   = data_q;
    assign kb.addr_kb   = 32'(KEY_ADDR);

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Scoreboard bench for ps2_kb_writer: stimulus pushes expected writes/errors,
// a monitor pops and compares whenever we_kb or frame_err is seen.
module tb_ps2_kb_writer;

    localparam int KEY_ADDR    = 10;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 20;   // clk cycles per PS/2 clock phase

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] last_written = 32'h0;

    ps2_kb_writer_if kb_if ();

    ps2_kb_writer #(.KEY_ADDR(KEY_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb       (kb_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
        last_written = d;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full 11-bit frame; par_flip corrupts parity, stop_val sets the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ par_flip);
        ps2_bit(stop_val);
        ps2_data = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    // Start bit plus n data bits, then the clock is left idle high.
    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
    endtask

    task automatic drain(input string name);
        repeat (10) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (kb_if.we_kb || kb_if.frame_err)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got we=%b err=%b data=%h expected none",
                             kb_if.we_kb, kb_if.frame_err, kb_if.data_kb);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_we",  32'(kb_if.we_kb),     32'(!e.is_err));
                    check("strobe_err", 32'(kb_if.frame_err), 32'(e.is_err));
                    if (!e.is_err) begin
                        check("write_data", kb_if.data_kb, e.data);
                        check("write_addr", kb_if.addr_kb, 32'(KEY_ADDR));
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",   32'(kb_if.we_kb),     32'd0);
        check("rst_err",  32'(kb_if.frame_err), 32'd0);
        check("rst_data", kb_if.data_kb,        32'd0);
        check("rst_addr", kb_if.addr_kb,        32'(KEY_ADDR));
        @(posedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Plain make code.
        expect_write(32'h0000_001C);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("make_1c");

        // Break of 1C.
`ifdef KB_BREAK_CLEAR_EN
        expect_write(32'h0000_0000);
`endif
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("break_1c");
        @(negedge clk);
        check("break_hold", kb_if.data_kb, last_written);

        // Extended make code.
        expect_write(32'h0000_0175);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("ext_75");

        // Bad parity, bad stop, then a good byte.
        expect_err();
        send_frame(8'h1C, 1'b1, 1'b1);
        expect_err();
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_write(32'h0000_001B);
        send_frame(8'h1B, 1'b0, 1'b1);
        drain("bad_frames");

        // Rejected frame keeps the pending extended prefix.
        expect_err();
        expect_write(32'h0000_0175);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("prefix_kept");

        // Typematic repeats.
        expect_write(32'h0000_001B);
        expect_write(32'h0000_001B);
        send_frame(8'h1B, 1'b0, 1'b1);
        send_frame(8'h1B, 1'b0, 1'b1);
        drain("typematic");

        // Stall after 4 data bits.
        expect_err();
        send_partial(8'h2A, 4);
        repeat (TIMEOUT_CYC + 1) @(posedge clk);
        drain("timeout_err");
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYC) @(posedge clk);
        drain("timeout_once");
        expect_write(32'h0000_002A);
        send_frame(8'h2A, 1'b0, 1'b1);
        drain("after_timeout");

        // Reset mid-frame.
        send_partial(8'h1C, 5);
        ps2_data = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_we",   32'(kb_if.we_kb),     32'd0);
        check("midrst_err",  32'(kb_if.frame_err), 32'd0);
        check("midrst_data", kb_if.data_kb,        32'd0);
        check("midrst_addr", kb_if.addr_kb,        32'(KEY_ADDR));
        repeat (TIMEOUT_CYC + 20) @(posedge clk);
        drain("midrst_quiet");
        expect_write(32'h0000_0016);
        send_frame(8'h16, 1'b0, 1'b1);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kb_writer.md
PS2_KB_WRITER -- requirements
Module: ps2_kb_writer

Interface
REQ-001 Parameter KEY_ADDR, default 10, SHALL be the word index (not byte address) driven on addr_kb.
REQ-002 Parameter TIMEOUT_CYC, default 50000, SHALL be the clk cycles allowed between PS/2 falling edges inside a frame.
REQ-003 Port clk  input  1  is the single system clock; all logic SHALL be rising-edge clocked on it.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-005 Port ps2_clk  input  1  is the asynchronous keyboard clock, idle high.
REQ-006 Port ps2_data  input  1  is the asynchronous keyboard data, idle high.
REQ-007 Port we_kb  output  1  is the write strobe to the data memory keyboard port.
REQ-008 Port addr_kb  output  32  is the word index for the write, constant KEY_ADDR.
REQ-009 Port data_kb  output  32  is the write data, {23'b0, ext, code[7:0]}.
REQ-010 Port frame_err  output  1  is a one-cycle pulse on any rejected frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; a falling edge SHALL be synced-previous 1 and synced-current 0.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on a detected falling edge, except timeout.
REQ-013 IDLE: falling edge with data 0 -> DATA, bit counter 0; falling edge with data 1 SHALL be ignored.
REQ-014 DATA: 8 bits shifted LSB first; after bit 7 -> PARITY.
REQ-015 PARITY: the sampled bit SHALL make odd parity over 8 data bits plus parity, else error flag set; -> STOP.
REQ-016 STOP: stop bit must be 1; -> IDLE; a frame is accepted only with correct parity and stop.
REQ-017 Rejected frame: frame_err SHALL pulse the cycle after STOP; no write; prefix flags unchanged.
REQ-018 In any non-IDLE state, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE and pulse frame_err once; counter clears on every edge.
REQ-019 Accepted byte 0xE0 SHALL set ext flag; 0xF0 SHALL set brk flag; neither writes.
REQ-020 Accepted other byte with brk clear: we_kb SHALL be high exactly one cycle, the cycle after the stop-bit edge is detected, data_kb = {23'b0, ext, byte}; both flags then clear.
REQ-021 Accepted other byte with brk set: behaviour per REQ-027/028; both flags then clear.
REQ-022 data_kb SHALL be registered and hold its last written value between strobes.
REQ-023 addr_kb SHALL equal KEY_ADDR at all times, including reset.
REQ-024 Repeated make codes (typematic) SHALL each produce a separate write.

Reset
REQ-025 While rst_n is 0 at a clk edge: FSM IDLE, counters 0, flags 0, we_kb 0, frame_err 0, data_kb 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL discard the partial frame with no write and no frame_err.

Configuration
REQ-027 With KB_BREAK_CLEAR_EN defined, a break-coded byte SHALL write data_kb = 0 (key released) with the REQ-020 timing.
REQ-028 Without KB_BREAK_CLEAR_EN, a break-coded byte SHALL produce no write; the last make code remains in memory.

Structure
REQ-029 Package kb_pkg SHALL hold the FSM state enum and constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0.
REQ-030 Sub-module ps2_sync_edge SHALL implement the synchronizers and falling-edge detector (REQ-011).

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> one we_kb pulse, data_kb = 0x0000001C, addr_kb = 10.
REQ-032 E0 then 0x75 -> single write, data_kb = 0x00000175; no write for E0.
REQ-033 F0 then 0x1C -> 0x00000000 written with KB_BREAK_CLEAR_EN; no write and data_kb stays 0x1C without it.
REQ-034 Frame 0x1C with parity 1 (or stop 0) -> frame_err one cycle, no we_kb, following valid 0x1B written normally.
REQ-035 Stall ps2_clk high after 4 data bits for TIMEOUT_CYC+1 cycles -> frame_err once, FSM IDLE, next full frame accepted.
REQ-036 rst_n low for 1 cycle after 5 data bits -> no write, no frame_err, outputs at reset values, next frame accepted.
